// File: rtl/desplazador_iterativo.sv
// Iterative shifter/rotator: one bit position per clock, with a
// valid/ready request side and a valid/ready result side.
module desplazador_iterativo #(
  parameter int ANCHO      = 8,
  parameter int ANCHO_CANT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  // Handshake rule on both sides: a transfer happens on a rising edge
  // where valid and ready are both 1. Valid may not depend on ready.
  input  logic                  entrada_valida,
  output logic                  entrada_lista,
  input  logic [ANCHO-1:0]      Desplazar,
  input  logic [ANCHO_CANT-1:0] Cantidad,
  input  logic [2:0]            Modo,
  output logic [ANCHO-1:0]      Desplazados,
  output logic                  Acarreo,
  output logic                  salida_valida,
  input  logic                  salida_lista,
  output logic                  ocupado,
  output logic [1:0]            estado_dbg
);

  localparam logic [1:0] LIBRE    = 2'b00;
  localparam logic [1:0] DESPLAZA = 2'b01;
  localparam logic [1:0] ENTREGA  = 2'b10;

  localparam logic [2:0] MODO_SLL = 3'b000;
  localparam logic [2:0] MODO_SRL = 3'b001;
  localparam logic [2:0] MODO_SRA = 3'b010;
  localparam logic [2:0] MODO_ROL = 3'b011;
  localparam logic [2:0] MODO_ROR = 3'b100;

  logic [1:0]            estado_q, estado_d;
  logic [ANCHO-1:0]      dato_q, dato_d;
  logic [ANCHO_CANT-1:0] cuenta_q, cuenta_d;
  logic [2:0]            modo_q, modo_d;
  logic                  acarreo_q, acarreo_d;
  logic                  valida_q, valida_d;

  logic [ANCHO-1:0]      paso_dato;
  logic                  paso_acarreo;

  // Single-position step for the latched mode; reserved codes hold everything.
  always_comb begin
    paso_dato    = dato_q;
    paso_acarreo = acarreo_q;
    case (modo_q)
      MODO_SLL: begin
        paso_dato    = {dato_q[ANCHO-2:0], 1'b0};
        paso_acarreo = dato_q[ANCHO-1];
      end
      MODO_SRL: begin
        paso_dato    = {1'b0, dato_q[ANCHO-1:1]};
        paso_acarreo = dato_q[0];
      end
      MODO_SRA: begin
        paso_dato    = {dato_q[ANCHO-1], dato_q[ANCHO-1:1]};
        paso_acarreo = dato_q[0];
      end
      MODO_ROL: begin
        paso_dato    = {dato_q[ANCHO-2:0], dato_q[ANCHO-1]};
        paso_acarreo = dato_q[ANCHO-1];
      end
      MODO_ROR: begin
        paso_dato    = {dato_q[0], dato_q[ANCHO-1:1]};
        paso_acarreo = dato_q[0];
      end
      default: begin
        paso_dato    = dato_q;
        paso_acarreo = acarreo_q;
      end
    endcase
  end

  always_comb begin
    estado_d  = estado_q;
    dato_d    = dato_q;
    cuenta_d  = cuenta_q;
    modo_d    = modo_q;
    acarreo_d = acarreo_q;
    valida_d  = valida_q;
    case (estado_q)
      LIBRE: begin
        if (entrada_valida) begin
          dato_d    = Desplazar;
          cuenta_d  = Cantidad;
          modo_d    = Modo;
          acarreo_d = 1'b0;
          estado_d  = DESPLAZA;
        end
      end
      DESPLAZA: begin
        // The zero-count cycle costs one extra edge, giving Cantidad+1 latency.
        if (cuenta_q != '0) begin
          dato_d    = paso_dato;
          acarreo_d = paso_acarreo;
          cuenta_d  = cuenta_q - ANCHO_CANT'(1);
        end else begin
          valida_d = 1'b1;
          estado_d = ENTREGA;
        end
      end
      ENTREGA: begin
        if (salida_lista) begin
          valida_d = 1'b0;
          estado_d = LIBRE;
        end
      end
      default: begin
        valida_d = 1'b0;
        estado_d = LIBRE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= LIBRE;
      dato_q    <= '0;
      cuenta_q  <= '0;
      modo_q    <= '0;
      acarreo_q <= 1'b0;
      valida_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      dato_q    <= dato_d;
      cuenta_q  <= cuenta_d;
      modo_q    <= modo_d;
      acarreo_q <= acarreo_d;
      valida_q  <= valida_d;
    end
  end

  assign entrada_lista = (estado_q == LIBRE);
  assign ocupado       = (estado_q != LIBRE);
  assign Desplazados   = dato_q;
  assign Acarreo       = acarreo_q;
  assign salida_valida = valida_q;
  assign estado_dbg    = estado_q;

endmodule

// File: tb/tb_desplazador_iterativo.sv
// Self-checking bench for desplazador_iterativo: directed table, reset abort,
// and random operations with a stalling consumer.
module tb_desplazador_iterativo;

  localparam int W = 15;  // {Desplazados[7:0], Acarreo, latency[5:0]}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       entrada_valida = 1'b0;
  logic       entrada_lista;
  logic [7:0] Desplazar = '0;
  logic [2:0] Cantidad = '0;
  logic [2:0] Modo = '0;
  logic [7:0] Desplazados;
  logic       Acarreo;
  logic       salida_valida;
  logic       salida_lista = 1'b0;
  logic       ocupado;
  logic [1:0] estado_dbg;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [2:0] modo;
    logic [7:0] dato;
    logic [2:0] cant;
    logic [7:0] exp_dato;
    logic       exp_acarreo;
    int         stall;
  } vec_t;

  vec_t tabla[6];

  desplazador_iterativo #(.ANCHO(8), .ANCHO_CANT(3)) dut (
    .clk(clk), .rst(rst),
    .entrada_valida(entrada_valida), .entrada_lista(entrada_lista),
    .Desplazar(Desplazar), .Cantidad(Cantidad), .Modo(Modo),
    .Desplazados(Desplazados), .Acarreo(Acarreo),
    .salida_valida(salida_valida), .salida_lista(salida_lista),
    .ocupado(ocupado), .estado_dbg(estado_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [8:0] ref_model(input logic [2:0] modo, input logic [7:0] dato,
                                           input logic [2:0] cant);
    logic [7:0] d;
    logic       c;
    d = dato;
    c = 1'b0;
    for (int i = 0; i < int'(cant); i++) begin
      case (modo)
        3'b000: begin c = d[7]; d = d << 1; end
        3'b001: begin c = d[0]; d = d >> 1; end
        3'b010: begin c = d[0]; d = $unsigned($signed(d) >>> 1); end
        3'b011: begin c = d[7]; d = {d[6:0], d[7]}; end
        3'b100: begin c = d[0]; d = {d[0], d[7:1]}; end
        default: ;
      endcase
    end
    return {d, c};
  endfunction

  task automatic run_op(input logic [2:0] modo, input logic [7:0] dato, input logic [2:0] cant,
                        input logic [7:0] ed, input logic ec, input int stall);
    int lat;
    logic [W-1:0] e;
    logic [7:0] snap_d;
    logic snap_c;
    @(negedge clk);
    check("entrada_lista_idle", entrada_lista, 1);
    Modo = modo; Desplazar = dato; Cantidad = cant; entrada_valida = 1'b1;
    exp_q.push_back({ed, ec, 6'(int'(cant) + 1)});
    @(posedge clk);
    @(negedge clk);
    check("busy_after_accept", {ocupado, entrada_lista}, 2'b10);
    lat = 0;
    while (!salida_valida && lat < 40) begin
      Desplazar = 8'($urandom); Modo = 3'($urandom); Cantidad = 3'($urandom);
      entrada_valida = 1'($urandom_range(0, 1));
      salida_lista = 1'($urandom_range(0, 1));
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!salida_valida) begin
      checks++; errors++;
      $display("FAIL latency_timeout: got no salida_valida within %0d edges", lat);
      void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got result %0h expected none", Desplazados);
    end else begin
      e = exp_q.pop_front();
      check("result_dato", Desplazados, e[14:7]);
      check("result_acarreo", Acarreo, e[6]);
      check("result_latency", lat, e[5:0]);
    end
    snap_d = Desplazados;
    snap_c = Acarreo;
    for (int k = 0; k < stall; k++) begin
      Desplazar = 8'($urandom); Modo = 3'($urandom); Cantidad = 3'($urandom);
      entrada_valida = 1'b1; salida_lista = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("stall_hold", {Desplazados, Acarreo, salida_valida, entrada_lista},
            {snap_d, snap_c, 1'b1, 1'b0});
    end
    salida_lista = 1'b1; entrada_valida = 1'b0;
    @(posedge clk);
    @(negedge clk);
    salida_lista = 1'b0;
    check("release_to_libre", {salida_valida, entrada_lista, ocupado, Desplazados},
          {1'b0, 1'b1, 1'b0, snap_d});
  endtask

  initial begin
    logic [8:0] r;
    int pulses;
    logic [2:0] m;
    logic [7:0] d;
    logic [2:0] c;

    tabla[0] = '{3'b000, 8'hB5, 3'd3, 8'hA8, 1'b1, 0};
    tabla[1] = '{3'b010, 8'h96, 3'd2, 8'hE5, 1'b1, 1};
    tabla[2] = '{3'b011, 8'h81, 3'd7, 8'hC0, 1'b0, 0};
    tabla[3] = '{3'b001, 8'h3C, 3'd0, 8'h3C, 1'b0, 2};
    tabla[4] = '{3'b110, 8'h5A, 3'd4, 8'h5A, 1'b0, 0};
    tabla[5] = '{3'b100, 8'h01, 3'd1, 8'h80, 1'b1, 5};

    // Reset with a request pending: must not be accepted.
    rst = 1'b1; entrada_valida = 1'b1; Desplazar = 8'hFF; Cantidad = 3'd5;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset_state", {Desplazados, Acarreo, salida_valida, ocupado, entrada_lista, estado_dbg},
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00});
    rst = 1'b0; entrada_valida = 1'b0;

    for (int i = 0; i < 6; i++)
      run_op(tabla[i].modo, tabla[i].dato, tabla[i].cant,
             tabla[i].exp_dato, tabla[i].exp_acarreo, tabla[i].stall);

    // Abort a ROR in its second DESPLAZA cycle; a request alongside rst is dropped.
    @(negedge clk);
    Modo = 3'b100; Desplazar = 8'hC3; Cantidad = 3'd7; entrada_valida = 1'b1;
    @(posedge clk);
    @(negedge clk);
    entrada_valida = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; entrada_valida = 1'b1; Desplazar = 8'h77;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; entrada_valida = 1'b0;
    check("abort_outputs", {Desplazados, Acarreo, salida_valida, ocupado, entrada_lista},
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (salida_valida) pulses++;
    end
    check("abort_no_valid_pulse", pulses, 0);

    for (int i = 0; i < 40; i++) begin
      m = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      c = 3'($urandom_range(0, 7));
      r = ref_model(m, d, c);
      run_op(m, d, c, r[8:1], r[0], $urandom_range(0, 3));
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
